// File: rtl/sseg_disp_mux_pwm_pkg.sv
// sseg_disp_mux_pwm_pkg: shared defaults and helpers for the seven-segment display blocks.
`default_nettype none
package sseg_disp_mux_pwm_pkg;

   localparam int DEF_DIGITS    = 4;
   localparam int DEF_SEG_W     = 8;
   localparam int DEF_PRESC_DIV = 8192;   // 100 MHz board clock -> ~763 Hz digit-slot rate
   localparam int DEF_BRIGHT_W  = 4;

   // Counter width for a modulo-n count; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_disp_mux_pwm_tick_gen.sv
// sseg_disp_mux_pwm_tick_gen: modulo-DIV counter, one-cycle tick in the cycle it wraps.
`default_nettype none
module sseg_disp_mux_pwm_tick_gen #(
   parameter int DIV = 8192,
   parameter int W   = 13
) (
   input  logic         clk,
   input  logic         reset,
   output logic [W-1:0] cnt_o,
   output logic         tick_o
);

   localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tick_o = (cnt_q == CNT_MAX);
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sseg_disp_mux_pwm.sv
// sseg_disp_mux_pwm: seven-segment digit multiplexer with enable mask, PWM brightness,
// guard sub-slot against ghosting and frame-synchronous input shadowing.
`default_nettype none
module sseg_disp_mux_pwm
   import sseg_disp_mux_pwm_pkg::*;
#(
   parameter int DIGITS    = DEF_DIGITS,
   parameter int SEG_W     = DEF_SEG_W,
   parameter int PRESC_DIV = DEF_PRESC_DIV,
   parameter int BRIGHT_W  = DEF_BRIGHT_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DIGITS*SEG_W-1:0] seg_in,
   input  logic [DIGITS-1:0]       dig_en,
   input  logic [BRIGHT_W-1:0]     bright,
   output logic [DIGITS-1:0]       an,
   output logic [SEG_W-1:0]        sseg,
   output logic                    frame_tick
);

   localparam int                  PW      = cnt_w(PRESC_DIV);
   localparam int                  DW      = cnt_w(DIGITS);
   localparam logic [BRIGHT_W-1:0] SUB_MAX = '1;
   localparam logic [DW-1:0]       DIG_MAX = DW'(DIGITS - 1);

   logic [PW-1:0]       presc;
   logic                presc_tick;
   logic [BRIGHT_W-1:0] sub_q, sub_d;
   logic [DW-1:0]       dig_q, dig_d;

   logic [DIGITS*SEG_W-1:0] sh_seg_q;
   logic [DIGITS-1:0]       sh_en_q;
   logic [BRIGHT_W-1:0]     sh_bright_q;
   logic                    load_pending_q;
   logic                    frame_tick_q;
   logic [DIGITS-1:0]       an_q, an_d;
   logic [SEG_W-1:0]        sseg_q, sseg_d;

   logic                    load;
   logic                    light;
   logic [SEG_W-1:0]        sh_seg_arr [DIGITS];

   sseg_disp_mux_pwm_tick_gen #(
      .DIV (PRESC_DIV),
      .W   (PW)
   ) u_presc (
      .clk    (clk),
      .reset  (reset),
      .cnt_o  (presc),
      .tick_o (presc_tick)
   );

   always_comb begin
      sub_d = sub_q;
      dig_d = dig_q;
      if (presc_tick) begin
         sub_d = sub_q + 1'b1;
         if (sub_q == SUB_MAX) begin
            dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
         end
      end
   end

   // Capture happens while all counters sit at zero, i.e. inside the guard sub-slot,
   // so the new shadows are in place before any segment of the frame lights.
   assign load = load_pending_q || ((presc == '0) && (sub_q == '0) && (dig_q == '0));

   for (genvar k = 0; k < DIGITS; k++) begin : g_seg_unpack
      assign sh_seg_arr[k] = sh_seg_q[k*SEG_W +: SEG_W];
   end

   assign light = sh_en_q[dig_q] && (sub_q != '0) && (sub_q <= sh_bright_q);

   always_comb begin
      an_d   = '1;
      sseg_d = '1;
      if (light) begin
         an_d   = ~(DIGITS'(1) << dig_q);
         sseg_d = sh_seg_arr[dig_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sub_q          <= '0;
         dig_q          <= '0;
         sh_seg_q       <= '1;
         sh_en_q        <= '0;
         sh_bright_q    <= '0;
         load_pending_q <= 1'b1;
         frame_tick_q   <= 1'b0;
         an_q           <= '1;
         sseg_q         <= '1;
      end else begin
         sub_q          <= sub_d;
         dig_q          <= dig_d;
         load_pending_q <= 1'b0;
         frame_tick_q   <= load;
         an_q           <= an_d;
         sseg_q         <= sseg_d;
         if (load) begin
            sh_seg_q    <= seg_in;
            sh_en_q     <= dig_en;
            sh_bright_q <= bright;
         end
      end
   end

   assign an         = an_q;
   assign sseg       = sseg_q;
   assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_disp_mux_pwm.sv
// tb_sseg_disp_mux_pwm: directed and random stimulus with a frame-position reference model.
`default_nettype none
module tb_sseg_disp_mux_pwm;

   localparam int DIGITS    = 3;
   localparam int SEG_W     = 8;
   localparam int PRESC_DIV = 2;
   localparam int BRIGHT_W  = 2;
   localparam int SLOT      = PRESC_DIV * (1 << BRIGHT_W);
   localparam int FRAME     = DIGITS * SLOT;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [DIGITS*SEG_W-1:0] seg_in = '0;
   logic [DIGITS-1:0]       dig_en = '0;
   logic [BRIGHT_W-1:0]     bright = '0;
   logic [DIGITS-1:0]       an;
   logic [SEG_W-1:0]        sseg;
   logic                    frame_tick;

   always #5 clk = ~clk;

   sseg_disp_mux_pwm #(
      .DIGITS    (DIGITS),
      .SEG_W     (SEG_W),
      .PRESC_DIV (PRESC_DIV),
      .BRIGHT_W  (BRIGHT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .seg_in     (seg_in),
      .dig_en     (dig_en),
      .bright     (bright),
      .an         (an),
      .sseg       (sseg),
      .frame_tick (frame_tick)
   );

   typedef struct packed {
      logic [DIGITS-1:0] an;
      logic [SEG_W-1:0]  sseg;
      logic              ft;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   int                      m_pos = 0;
   logic                    m_pend = 1'b1;
   logic [DIGITS*SEG_W-1:0] m_seg = '1;
   logic [DIGITS-1:0]       m_en = '0;
   logic [BRIGHT_W-1:0]     m_br = '0;

   int         cyc = 0;
   int         lit_cnt [DIGITS];
   logic [7:0] seen_seg [DIGITS];
   int         ft_last = -1;
   int         ft_period = 0;
   int         ft_first = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      for (int k = 0; k < DIGITS; k++) begin
         lit_cnt[k]  = 0;
         seen_seg[k] = 8'h00;
      end
   endtask

   task automatic tick();
      exp_t e;
      int   d;
      int   s;
      if (reset) begin
         e.an   = '1;
         e.sseg = '1;
         e.ft   = 1'b0;
         m_pos  = 0;
         m_pend = 1'b1;
         m_seg  = '1;
         m_en   = '0;
         m_br   = '0;
      end else begin
         d = m_pos / SLOT;
         s = (m_pos % SLOT) / PRESC_DIV;
         if (m_en[d] && s != 0 && s <= int'(m_br)) begin
            e.an   = ~(3'b001 << d);
            e.sseg = m_seg[d*SEG_W +: SEG_W];
         end else begin
            e.an   = '1;
            e.sseg = '1;
         end
         e.ft = m_pend || (m_pos == 0);
         if (e.ft) begin
            m_seg  = seg_in;
            m_en   = dig_en;
            m_br   = bright;
            m_pend = 1'b0;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = q.pop_front();
      chk("an", 32'(an), 32'(e.an));
      chk("sseg", 32'(sseg), 32'(e.sseg));
      chk("frame_tick", 32'(frame_tick), 32'(e.ft));
      chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
      for (int k = 0; k < DIGITS; k++) begin
         if (an[k] === 1'b0) begin
            lit_cnt[k]++;
            seen_seg[k] = sseg;
         end
      end
      if (frame_tick === 1'b1) begin
         if (ft_first < 0) ft_first = cyc;
         if (ft_last >= 0) ft_period = cyc - ft_last;
         ft_last = cyc;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      // 1: reset, then full-brightness frame
      reset  = 1'b1;
      seg_in = {8'hC0, 8'hF9, 8'hA4};
      dig_en = 3'b111;
      bright = 2'd3;
      run(5);
      chk("reset_an", 32'(an), 32'h7);
      chk("reset_sseg", 32'(sseg), 32'hFF);
      chk("reset_ft", 32'(frame_tick), 32'h0);
      reset = 1'b0;
      clear_stats();
      ft_first = -1;
      cyc = 0;
      run(FRAME);
      chk("first_ft_cycle", 32'(ft_first), 32'd1);
      chk("b3_lit0", 32'(lit_cnt[0]), 32'd6);
      chk("b3_lit1", 32'(lit_cnt[1]), 32'd6);
      chk("b3_lit2", 32'(lit_cnt[2]), 32'd6);
      chk("b3_seg0", 32'(seen_seg[0]), 32'hA4);
      chk("b3_seg1", 32'(seen_seg[1]), 32'hF9);
      chk("b3_seg2", 32'(seen_seg[2]), 32'hC0);

      // 2: minimum and zero brightness
      bright = 2'd1;
      clear_stats();
      run(FRAME);
      chk("b1_lit0", 32'(lit_cnt[0]), 32'd2);
      chk("b1_lit1", 32'(lit_cnt[1]), 32'd2);
      chk("b1_lit2", 32'(lit_cnt[2]), 32'd2);
      bright = 2'd0;
      clear_stats();
      run(FRAME);
      chk("b0_lit_total", 32'(lit_cnt[0] + lit_cnt[1] + lit_cnt[2]), 32'd0);

      // 3: digit 1 masked off
      bright = 2'd3;
      dig_en = 3'b101;
      clear_stats();
      run(FRAME);
      chk("mask_lit0", 32'(lit_cnt[0]), 32'd6);
      chk("mask_lit1", 32'(lit_cnt[1]), 32'd0);
      chk("mask_lit2", 32'(lit_cnt[2]), 32'd6);

      // 4: mid-frame data change is held off until the next frame
      dig_en = 3'b111;
      run(FRAME);
      clear_stats();
      run(FRAME / 2);
      seg_in[7:0] = 8'h92;
      run(FRAME / 2);
      chk("tear_old_seg0", 32'(seen_seg[0]), 32'hA4);
      clear_stats();
      run(FRAME);
      chk("tear_new_seg0", 32'(seen_seg[0]), 32'h92);
      chk("ft_period", 32'(ft_period), 32'(FRAME));

      // 5: reset in the middle of digit 1's lit window
      run(12);
      chk("pre_reset_an", 32'(an), 32'h5);
      reset = 1'b1;
      run(1);
      chk("midreset_an", 32'(an), 32'h7);
      chk("midreset_sseg", 32'(sseg), 32'hFF);
      chk("midreset_ft", 32'(frame_tick), 32'h0);
      run(2);
      reset = 1'b0;
      clear_stats();
      ft_first = -1;
      ft_last  = -1;
      cyc = 0;
      run(FRAME);
      chk("restart_ft_cycle", 32'(ft_first), 32'd1);
      chk("restart_lit0", 32'(lit_cnt[0]), 32'd6);
      chk("restart_seg0", 32'(seen_seg[0]), 32'h92);
      chk("restart_seg2", 32'(seen_seg[2]), 32'hC0);

      // 6: random inputs with occasional reset
      for (int i = 0; i < 10000; i++) begin
         seg_in = {$urandom, $urandom};
         dig_en = DIGITS'($urandom);
         bright = BRIGHT_W'($urandom);
         reset  = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0;
      run(FRAME);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
